// File: rtl/dm_output_poller_if.sv
// DataMem read port shared between the CPU (owner) and the output poller (yields on cpu_dm_cs).
interface dm_output_poller_if;
  logic        cpu_dm_cs;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;

  modport master (input cpu_dm_cs, input dm_rdata, output dm_req, output dm_addr);
  modport slave  (output cpu_dm_cs, output dm_rdata, input dm_req, input dm_addr);
endinterface

// File: rtl/dm_output_poller.sv
// Periodically sweeps the CPU output window in DataMem into shadow registers for the LCD mux,
// always yielding the memory port to the CPU and flagging words whose value changed.
module dm_output_poller #(
  parameter int          NUM_WORDS     = 2,
  parameter logic [31:0] BASE_ADDR     = 32'h8,
  parameter int          STRIDE        = 4,
  parameter int          POLL_INTERVAL = 1000,
  parameter int          READ_LATENCY  = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  dm_output_poller_if.master        dm,
  input  logic                      force_poll,
  output logic [32*NUM_WORDS-1:0]   out_data,
  output logic [NUM_WORDS-1:0]      out_changed,
  output logic                      sweep_done,
  output logic                      busy
);

  localparam int             TW           = $clog2(POLL_INTERVAL);
  localparam int             IW           = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [TW-1:0]  TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [1:0]     LAT_RELOAD   = 2'(READ_LATENCY - 1);
  localparam logic [IW-1:0]  LAST_IDX     = IW'(NUM_WORDS - 1);
  localparam logic [31:0]    STRIDE_W     = 32'(STRIDE);

  typedef enum logic [1:0] {IDLE, ARB, READ, CAPTURE} state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic [1:0]    lat_cnt;
  logic [31:0]   held;
  logic          last_word;

  assign last_word  = (idx == LAST_IDX);
  assign busy       = (state != IDLE);
  assign sweep_done = (state == CAPTURE) && last_word;
  // The CPU must win in the very cycle it asserts chip select, so no register here.
  assign dm.dm_req  = (state == READ) && !dm.cpu_dm_cs;
  assign dm.dm_addr = BASE_ADDR + (32'(idx) * STRIDE_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (timer == '0 || force_poll) next_state = ARB;
      ARB:     if (!dm.cpu_dm_cs) next_state = READ;
      READ: begin
        if (dm.cpu_dm_cs)        next_state = ARB;
        else if (lat_cnt == '0)  next_state = CAPTURE;
      end
      CAPTURE: next_state = last_word ? IDLE : ARB;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer    <= TIMER_RELOAD;
      idx      <= '0;
      lat_cnt  <= '0;
      held     <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= timer - 1'b1;
          if (next_state == ARB) idx <= '0;
        end
        ARB: begin
          if (!dm.cpu_dm_cs) lat_cnt <= LAT_RELOAD;
        end
        READ: begin
          // An aborted read simply falls back to ARB, which reloads the latency count.
          if (!dm.cpu_dm_cs) begin
            lat_cnt <= lat_cnt - 1'b1;
            if (lat_cnt == '0) held <= dm.dm_rdata;
          end
        end
        CAPTURE: begin
          out_data[32*idx +: 32] <= held;
          if (last_word) timer <= TIMER_RELOAD;
          else           idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_changed = '0;
    if (state == CAPTURE && held != out_data[32*idx +: 32]) out_changed[idx] = 1'b1;
  end

endmodule

// File: tb/tb_dm_output_poller.sv
// Randomized bench for dm_output_poller: a free-cycle-counting model of the sweep is checked
// against the DUT every cycle, plus directed scenarios pinned with hand-computed literals.
module tb_dm_output_poller;

  localparam int          NW   = 3;
  localparam int          RL   = 3;
  localparam int          PI   = 16;
  localparam int          STR  = 4;
  localparam logic [31:0] BASE = 32'h8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cpu_cs;
  logic              force_poll;
  logic [32*NW-1:0]  out_data;
  logic [NW-1:0]     out_changed;
  logic              sweep_done;
  logic              busy;
  logic [31:0]       mem [NW];
  logic [31:0]       rd_val;

  int tests = 0;
  int failures = 0;

  dm_output_poller_if dm_bus ();

  dm_output_poller #(
    .NUM_WORDS(NW), .BASE_ADDR(BASE), .STRIDE(STR), .POLL_INTERVAL(PI), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .resetn(resetn), .dm(dm_bus.master), .force_poll(force_poll),
    .out_data(out_data), .out_changed(out_changed), .sweep_done(sweep_done), .busy(busy)
  );

  always #5 clk = ~clk;

  assign dm_bus.cpu_dm_cs = cpu_cs;
  assign dm_bus.dm_rdata  = rd_val;

  // Out-of-window addresses return a recognisable pattern so a wrong address shows up as bad data.
  always_comb begin
    logic [31:0] off;
    off    = dm_bus.dm_addr - BASE;
    rd_val = 32'hBAD0_0000 ^ off;
    if ((off % STR) == 0 && (off / STR) < NW) rd_val = mem[off / STR];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic fp, input int n);
    repeat (n) begin
      cpu_cs     = cs;
      force_poll = fp;
      @(posedge clk);
      #1;
    end
  endtask

  // Model: a word completes after 1+RL consecutive cycles without CPU chip select, then one
  // capture cycle; any CPU cycle throws that progress away.
  bit          m_idle;
  bit          m_cap;
  int          m_icnt;
  int          m_word;
  int          m_prog;
  logic [31:0] m_hold;
  logic [31:0] m_shadow [NW];

  always @(negedge clk) begin
    logic          req_e, done_e;
    logic [NW-1:0] chg_e;
    if (!resetn) begin
      m_idle = 1; m_cap = 0; m_icnt = 0; m_word = 0; m_prog = 0;
      for (int w = 0; w < NW; w++) m_shadow[w] = '0;
      checkOutput("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
      checkOutput("rst_dm_addr", dm_bus.dm_addr, BASE);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_changed", 32'(out_changed), 32'd0);
      checkOutput("rst_done", 32'(sweep_done), 32'd0);
      checkOutput("rst_out_data", 32'(out_data != '0), 32'd0);
    end else begin
      req_e  = !m_idle && !m_cap && m_prog >= 1 && !cpu_cs;
      done_e = m_cap && (m_word == NW - 1);
      chg_e  = '0;
      if (m_cap) chg_e[m_word] = (m_hold != m_shadow[m_word]);
      checkOutput("busy", 32'(busy), 32'(!m_idle));
      checkOutput("dm_req", 32'(dm_bus.dm_req), 32'(req_e));
      if (req_e) checkOutput("dm_addr", dm_bus.dm_addr, BASE + 32'(m_word * STR));
      checkOutput("out_changed", 32'(out_changed), 32'(chg_e));
      checkOutput("sweep_done", 32'(sweep_done), 32'(done_e));
      for (int w = 0; w < NW; w++) checkOutput("out_data", out_data[32*w +: 32], m_shadow[w]);

      if (m_idle) begin
        if (force_poll || m_icnt == PI - 1) begin
          m_idle = 0; m_word = 0; m_prog = 0; m_cap = 0;
        end else m_icnt++;
      end else if (m_cap) begin
        m_shadow[m_word] = m_hold;
        m_cap = 0;
        if (m_word == NW - 1) begin
          m_idle = 1; m_icnt = 0;
        end else begin
          m_word++; m_prog = 0;
        end
      end else if (cpu_cs) m_prog = 0;
      else begin
        m_prog++;
        if (m_prog == RL + 1) begin
          m_hold = mem[m_word];
          m_cap  = 1;
        end
      end
    end
  end

  // Per-sweep statistics for the hand-computed checks.
  int          cur_len = 0, cur_done = 0, last_len = 0, last_done = 0, sweeps_seen = 0;
  logic [NW-1:0] cur_or = '0, last_or = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      cur_len = 0; cur_done = 0; cur_or = '0;
    end else if (busy) begin
      cur_len++;
      cur_done += int'(sweep_done);
      cur_or |= out_changed;
    end else if (cur_len != 0) begin
      last_len = cur_len; last_done = cur_done; last_or = cur_or;
      sweeps_seen++;
      cur_len = 0; cur_done = 0; cur_or = '0;
    end
  end

  task automatic waitSweeps(input int target, input string name);
    int i;
    for (i = 0; i < 400 && sweeps_seen < target; i++) @(posedge clk);
    #1;
    if (sweeps_seen < target) checkOutput({name, "_timeout"}, 32'(sweeps_seen), 32'(target));
  endtask

  initial begin
    int n;
    resetn = 1'b0; cpu_cs = 1'b0; force_poll = 1'b0;
    mem[0] = 32'd5; mem[1] = 32'd7; mem[2] = 32'h11;
    applyStimulus(0, 0, 3);
    resetn = 1'b1;

    // First sweep: every word differs from the reset value of 0.
    waitSweeps(1, "sweep1");
    checkOutput("sweep1_len", 32'(last_len), 32'd15);
    checkOutput("sweep1_word0", out_data[31:0], 32'd5);
    checkOutput("sweep1_word1", out_data[63:32], 32'd7);
    checkOutput("sweep1_changed", 32'(last_or), 32'b111);
    checkOutput("sweep1_done", 32'(last_done), 32'd1);

    // Second sweep over unchanged memory.
    waitSweeps(2, "sweep2");
    checkOutput("sweep2_changed", 32'(last_or), 32'd0);
    checkOutput("sweep2_done", 32'(last_done), 32'd1);

    // CPU owns memory for the first 10 cycles of the sweep.
    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 10);
    applyStimulus(0, 0, 1);
    waitSweeps(3, "contend");
    checkOutput("contend_len", 32'(last_len), 32'd25);

    // CPU steals the second READ cycle of word 0; word 1 changes 7 -> 9.
    mem[1] = 32'd9;
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 2);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    waitSweeps(4, "abort");
    checkOutput("abort_len", 32'(last_len), 32'd18);
    checkOutput("abort_changed", 32'(last_or), 32'b010);
    checkOutput("abort_word1", out_data[63:32], 32'd9);

    // force_poll mid-interval starts a sweep next cycle; repeats during the sweep are dropped.
    applyStimulus(0, 0, 5);
    applyStimulus(0, 1, 1);
    force_poll = 1'b0;
    @(negedge clk);
    checkOutput("force_start_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    applyStimulus(0, 1, 10);
    applyStimulus(0, 0, 1);
    waitSweeps(5, "force");
    applyStimulus(0, 0, 8);
    checkOutput("force_no_requeue", 32'(busy), 32'd0);
    checkOutput("force_sweep_count", 32'(sweeps_seen), 32'd5);

    // Reset lands in the second READ cycle of word 1.
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 7);
    checkOutput("pre_reset_req", 32'(dm_bus.dm_req), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("reset_req_now", 32'(dm_bus.dm_req), 32'd0);
    checkOutput("reset_data_now", 32'(out_data != '0), 32'd0);
    checkOutput("reset_busy_now", 32'(busy), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) break;
      n++;
    end
    checkOutput("idle_after_reset", 32'(n), 32'(PI));
    @(posedge clk); #1;

    // Random contention, force requests, memory updates and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      resetn     = ($urandom_range(0, 999) >= 3);
      cpu_cs     = ($urandom_range(0, 99) < 30);
      force_poll = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 8) mem[$urandom_range(0, NW - 1)] = 32'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    applyStimulus(0, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
